// File: rtl/uart_pkg.sv
// Frame constants and receiver state encoding, shared by the 8-bit UART transmitter and receiver.
package uart_pkg;

  localparam int   DATA_W     = 8;
  localparam logic STOP_LEVEL = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_RESET     = 3'b001,
    ST_IDLE      = 3'b010,
    ST_START     = 3'b011,
    ST_DATA      = 3'b100,
    ST_STOP      = 3'b101,
    ST_WAIT_HIGH = 3'b110
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart8_receiver.sv
// 8N1 UART receiver at OVERSAMPLE x baud with start qualification, mid-bit sampling and framing check.
// Define UART_RX_MAJORITY_EN to take every sample as a 2-of-3 vote around mid-bit.
module uart8_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in,
  output logic [DATA_W-1:0] out,
  output logic              done,
  output logic              busy,
  output logic              err,
  output logic [2:0]        state_o
);

  localparam int            TW   = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [TW-1:0] SAMP_T = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] SAMP_T = MID;
`endif

  rx_state_e         state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              rx_s;
  logic              sample;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (in),
    .q_o (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds rx_s from ticks MID-1 and MID when the vote is taken at MID+1.
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hist_q <= 2'b11;
    else     hist_q <= {hist_q[0], rx_s};
  end

  assign sample = maj3(hist_q[1], hist_q[0], rx_s);
`else
  assign sample = rx_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RESET;
      tick_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      out_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      out_q     <= out_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    out_d     = out_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    err_d     = err_q;
    case (state_q)
      ST_RESET: begin
        tick_d  = '0;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        tick_d = '0;
        if (en && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == SAMP_T) begin
          if (sample) begin
            // Low pulse shorter than half a bit: treat as line noise.
            tick_d  = '0;
            state_d = ST_IDLE;
          end else begin
            busy_d = 1'b1;
            err_d  = 1'b0;
          end
        end
        if (tick_q == LAST) begin
          tick_d    = '0;
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == SAMP_T) shreg_d[bit_idx_q] = sample;
        if (tick_q == LAST) begin
          tick_d    = '0;
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        tick_d = tick_q + 1'b1;
        if (tick_q == SAMP_T) begin
          tick_d = '0;
          busy_d = 1'b0;
          if (sample == STOP_LEVEL) begin
            out_d   = shreg_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A held-low line (break) must release before another start is accepted.
        tick_d = '0;
        if (rx_s == IDLE_LEVEL) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  assign out     = out_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule
